// File: rtl/jt51_phseq.sv
// Time-multiplexed phase generator for 32 operator slots: per-slot phase
// accumulation, phase modulation and quarter-wave fold onto sine-ROM rows.
module jt51_phseq #(
    parameter int PH_W  = 20,
    parameter int SLOTS = 32
) (
    input  logic                     rst,
    input  logic                     clk,
    input  logic                     cen,
    input  logic [PH_W-1:0]          phinc_I,
    input  logic                     pg_rst_I,
    input  logic [9:0]               pm_I,
    output logic [$clog2(SLOTS)-1:0] slot,
    output logic [4:0]               rom_addr,
    output logic [2:0]               sub_o,
    output logic                     sign_o,
    output logic [9:0]               ph_o
);
    localparam int SW = $clog2(SLOTS);
    localparam logic [SW-1:0] SLOT_STEP = SW'(1);

    logic [PH_W-1:0] acc_q [SLOTS];
    logic [SW-1:0]   slot_q;

    // Only the top ten phase bits leave stage 0; the low bits live on in acc_q.
    logic [9:0]      ph_q, pm_q;
    logic [9:0]      mod_q;
    logic [4:0]      addr_q;
    logic [2:0]      sub_q;
    logic            sign_q;
    logic [9:0]      ph2_q;
    logic [2:0]      sub_out_q;
    logic            sign_out_q;
    logic [9:0]      ph_out_q;

    logic [PH_W-1:0] acc_d;
    logic [9:0]      mod_d;
    logic [7:0]      idx_d;

    always_comb begin
        acc_d = pg_rst_I ? '0 : acc_q[slot_q] + phinc_I;
        mod_d = ph_q + pm_q;
        // Second quarter of each half-wave reads the table backwards.
        idx_d = mod_q[8] ? ~mod_q[7:0] : mod_q[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                acc_q[i] <= '0;
            end
            slot_q     <= '0;
            ph_q       <= '0;
            pm_q       <= '0;
            mod_q      <= '0;
            addr_q     <= '0;
            sub_q      <= '0;
            sign_q     <= 1'b0;
            ph2_q      <= '0;
            sub_out_q  <= '0;
            sign_out_q <= 1'b0;
            ph_out_q   <= '0;
        end else if (cen) begin
            acc_q[slot_q] <= acc_d;
            slot_q        <= slot_q + SLOT_STEP;
            ph_q          <= acc_d[PH_W-1 -: 10];
            pm_q          <= pm_I;
            mod_q         <= mod_d;
            addr_q        <= idx_d[7:3];
            sub_q         <= idx_d[2:0];
            sign_q        <= mod_q[9];
            ph2_q         <= mod_q;
            // Extra stage matches the ROM's registered read.
            sub_out_q     <= sub_q;
            sign_out_q    <= sign_q;
            ph_out_q      <= ph2_q;
        end
    end

    assign slot     = slot_q;
    assign rom_addr = addr_q;
    assign sub_o    = sub_out_q;
    assign sign_o   = sign_out_q;
    assign ph_o     = ph_out_q;
endmodule

// File: tb/tb_jt51_phseq.sv
// Directed bench for jt51_phseq: reset, accumulation, key-on, wrap/fold,
// modulation and clock-enable gating against hand-computed values.
module tb_jt51_phseq;
    logic        rst;
    logic        clk;
    logic        cen;
    logic [19:0] phinc_I;
    logic        pg_rst_I;
    logic [9:0]  pm_I;
    logic [4:0]  slot;
    logic [4:0]  rom_addr;
    logic [2:0]  sub_o;
    logic        sign_o;
    logic [9:0]  ph_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] tb_slot;

    logic [19:0] v_phinc [12];
    logic        v_pg    [12];
    logic [9:0]  v_pm    [12];
    logic [9:0]  v_ph    [12];
    logic [4:0]  v_addr  [12];
    logic [2:0]  v_sub   [12];
    logic        v_sign  [12];

    jt51_phseq dut (
        .rst      (rst),
        .clk      (clk),
        .cen      (cen),
        .phinc_I  (phinc_I),
        .pg_rst_I (pg_rst_I),
        .pm_I     (pm_I),
        .slot     (slot),
        .rom_addr (rom_addr),
        .sub_o    (sub_o),
        .sign_o   (sign_o),
        .ph_o     (ph_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (cen && !rst) tb_slot = tb_slot + 5'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cen = 1'b1; phinc_I = '0; pg_rst_I = 1'b0; pm_I = '0;
        step();
        rst = 1'b0;
        tb_slot = '0;
    endtask

    task automatic set_vis(input int j, input logic [19:0] inc, input logic pg, input logic [9:0] pm,
                           input logic [9:0] ph, input logic [4:0] addr, input logic [2:0] sub,
                           input logic sign);
        v_phinc[j] = inc; v_pg[j] = pg; v_pm[j] = pm;
        v_ph[j] = ph; v_addr[j] = addr; v_sub[j] = sub; v_sign[j] = sign;
    endtask

    // Drives slot s from the visit table, other slots idle; checks each visit's outputs.
    task automatic run_vis(input string tag, input logic [4:0] s, input int nv, input int cen_div);
        int k = 0;
        int e = 0;
        int last_e = -100;
        logic drove;
        for (int i = 0; i < (32 * nv + 6) * cen_div; i++) begin
            cen = ((i % cen_div) == 0);
            if (tb_slot == s && k < nv) begin
                phinc_I = v_phinc[k]; pg_rst_I = v_pg[k]; pm_I = v_pm[k];
            end else begin
                phinc_I = '0; pg_rst_I = 1'b0; pm_I = '0;
            end
            drove = (tb_slot == s && k < nv && cen);
            step();
            if (cen) begin
                e++;
                if (drove) begin
                    k++;
                    last_e = e;
                end
            end
            chk({tag, ".slot"}, 20'(slot), 20'(tb_slot));
            if (e == last_e + 2) chk({tag, ".rom_addr"}, 20'(rom_addr), 20'(v_addr[k-1]));
            if (e == last_e + 3) begin
                chk({tag, ".ph_o"}, 20'(ph_o), 20'(v_ph[k-1]));
                chk({tag, ".sub_o"}, 20'(sub_o), 20'(v_sub[k-1]));
                chk({tag, ".sign_o"}, 20'(sign_o), 20'(v_sign[k-1]));
            end
            if (e == last_e + 4) chk({tag, ".neighbour_ph_o"}, 20'(ph_o), 20'h0);
        end
        cen = 1'b1;
    endtask

    initial begin
        tb_slot = '0;
        rst = 1'b1; cen = 1'b1; phinc_I = 20'h12345; pg_rst_I = 1'b0; pm_I = 10'h003;
        step(); step(); step();
        chk("reset.slot", 20'(slot), 20'h0);
        chk("reset.rom_addr", 20'(rom_addr), 20'h0);
        chk("reset.ph_o", 20'(ph_o), 20'h0);
        chk("reset.sub_o", 20'(sub_o), 20'h0);
        chk("reset.sign_o", 20'(sign_o), 20'h0);

        // Release with every slot fed 0x12345 and pm=3: phase top 0x048 + 3 = 0x04B.
        rst = 1'b0;
        tb_slot = '0;
        step();
        chk("release.e1.ph_o", 20'(ph_o), 20'h0);
        chk("release.e1.rom_addr", 20'(rom_addr), 20'h0);
        step();
        chk("release.e2.ph_o", 20'(ph_o), 20'h0);
        chk("release.e2.rom_addr", 20'(rom_addr), 20'h0);
        step();
        chk("release.e3.ph_o", 20'(ph_o), 20'h0);
        chk("release.e3.rom_addr", 20'(rom_addr), 20'h09);
        step();
        chk("release.e4.ph_o", 20'(ph_o), 20'h04B);
        chk("release.e4.sub_o", 20'(sub_o), 20'h3);
        chk("release.e4.sign_o", 20'(sign_o), 20'h0);
        for (int i = 4; i < 33; i++) begin
            step();
            chk("count.slot", 20'(slot), 20'(tb_slot));
        end
        chk("count.wrapped", 20'(slot), 20'h01);

        // Asynchronous reset between edges with a full pipeline.
        rst = 1'b1;
        #1;
        chk("midrst.slot", 20'(slot), 20'h0);
        chk("midrst.rom_addr", 20'(rom_addr), 20'h0);
        chk("midrst.ph_o", 20'(ph_o), 20'h0);
        chk("midrst.sub_o", 20'(sub_o), 20'h0);
        chk("midrst.sign_o", 20'(sign_o), 20'h0);
        step();

        // Accumulation: slot 5 gets 0x00400 per visit, so phase k on visit k.
        do_reset();
        for (int j = 0; j < 10; j++) begin
            set_vis(j, 20'h00400, 1'b0, 10'h0, 10'(j + 1), 5'((j + 1) >> 3), 3'((j + 1) & 7), 1'b0);
        end
        run_vis("accum", 5'd5, 10, 1);

        // Key-on: jump to 0x2A3, then pg_rst clears, then one step to 1.
        do_reset();
        set_vis(0, 20'hA8C00, 1'b0, 10'h0, 10'h2A3, 5'd20, 3'd3, 1'b1);
        set_vis(1, 20'h00400, 1'b1, 10'h0, 10'h000, 5'd0, 3'd0, 1'b0);
        set_vis(2, 20'h00400, 1'b0, 10'h0, 10'h001, 5'd0, 3'd1, 1'b0);
        run_vis("keyon", 5'd5, 3, 1);

        // Negative increment walks the phase down through the accumulator wrap.
        do_reset();
        set_vis(0, 20'hFFC00, 1'b0, 10'h0, 10'h3FF, 5'd0, 3'd0, 1'b1);
        set_vis(1, 20'hFFC00, 1'b0, 10'h0, 10'h3FE, 5'd0, 3'd1, 1'b1);
        set_vis(2, 20'hFFC00, 1'b0, 10'h0, 10'h3FD, 5'd0, 3'd2, 1'b1);
        run_vis("wrap", 5'd0, 3, 1);

        // Fold points reached through pm alone on a zero accumulator.
        do_reset();
        set_vis(0, 20'h0, 1'b0, 10'h0FF, 10'h0FF, 5'd31, 3'd7, 1'b0);
        set_vis(1, 20'h0, 1'b0, 10'h100, 10'h100, 5'd31, 3'd7, 1'b0);
        set_vis(2, 20'h0, 1'b0, 10'h1FF, 10'h1FF, 5'd0, 3'd0, 1'b0);
        run_vis("fold", 5'd12, 3, 1);

        // 0x3F0 + pm 0x020 wraps to 0x010; next visit shows 0x3F1 unmodulated.
        do_reset();
        set_vis(0, 20'hFC000, 1'b0, 10'h020, 10'h010, 5'd2, 3'd0, 1'b0);
        set_vis(1, 20'h00400, 1'b0, 10'h000, 10'h3F1, 5'd1, 3'd6, 1'b1);
        run_vis("modul", 5'd3, 2, 1);

        // Same stimulus with cen high every cycle and then one cycle in three.
        for (int j = 0; j < 4; j++) begin
            set_vis(j, 20'h00800, 1'b0, 10'h005, 10'(2 * j + 7), 5'((2 * j + 7) >> 3),
                    3'((2 * j + 7) & 7), 1'b0);
        end
        do_reset();
        run_vis("cen_full", 5'd2, 4, 1);
        do_reset();
        run_vis("cen_gated", 5'd2, 4, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/jt51_phseq.md
Name: jt51_phseq

Overview:
- Time-multiplexed phase sequencer for the 32 operator slots.
- Keeps a 20-bit phase accumulator per slot, applies phase modulation, and folds the phase to a quarter wave.
- Drives the 5-bit address of the downstream 32x46 sine-row ROM, which has a registered 1-cycle read.
- Supplies sub-row select and sign, delayed to line up with the ROM output word for the log-sine decode stage.

Parameters:
- PH_W, 20, accumulator width; output phase is the top 10 bits.
- SLOTS, 32, number of time-multiplexed slots; power of two.

Ports:
- rst  input  1  asynchronous reset, active-high
- clk  input  1  clock
- cen  input  1  clock enable; all state advances only when high
- phinc_I  input  20  phase increment for the slot currently at the input
- pg_rst_I  input  1  key-on phase reset for the current slot
- pm_I  input  10  phase modulation (operator feedback/FM) for the current slot
- slot  output  5  index of the slot whose phinc/pg_rst/pm are sampled this cycle
- rom_addr  output  5  ROM row address
- sub_o  output  3  bit-group select within the ROM word; aligned with ROM data
- sign_o  output  1  negative half-wave; aligned with ROM data
- ph_o  output  10  modulated phase; aligned with ROM data, for debug/bench

Behaviour:
- Reset (async, rst=1): all 32 accumulators are 0; slot=0; all pipeline registers are 0, so rom_addr=0, sub_o=0, sign_o=0, ph_o=0. Release takes effect on the next enabled edge.
- cen=0: no state changes and outputs hold. All latencies below are counted in enabled edges.
- Slot counter: slot increments mod 32 on each enabled edge.
- Accumulator store:
  - 32x20 circular buffer (shift register or RAM); each slot is read once per 32 enabled edges.
- Stage 0 (edge E, current slot s):
  - new = pg_rst_I ? 0 : acc[s] + phinc_I, truncated to 20 bits (wraps at 2^20).
  - Write new back to acc[s]; register new into ph_q and pm_I into pm_q.
  - pg_rst_I=1 forces new=0, so that slot's phase is 0 in the pipeline; phinc is not added on that visit.
- Stage 1 (E+1): mod_q = ph_q[19:10] + pm_q, mod 1024.
- Stage 2 (E+2), quarter-wave fold:
  - idx = mod_q[8] ? ~mod_q[7:0] : mod_q[7:0].
  - rom_addr <= idx[7:3]; also register sub=idx[2:0], sign=mod_q[9], ph=mod_q.
- Stage 3 (E+3):
  - sub_o/sign_o/ph_o <= stage-2 values.
  - ROM data for rom_addr also appears at E+3, so all three outputs are aligned with it.
- Latency: inputs at edge E → rom_addr at E+2 → sub_o/sign_o/ph_o at E+3. Throughput is 1 slot per enabled edge with no stalls.
- Per-slot independence: updates for slot s never modify other slots.
- pm does not alter the stored accumulator; it affects only the output path.
- Reset mid-operation:
  - Pipeline contents are discarded and accumulators are cleared.
  - After release, slot restarts at 0 and outputs read 0 until new data propagates (3 enabled edges).
- Boundaries:
  - Accumulator wraps from 0xFFFFF+1 to 0.
  - mod_q wraps 1023+1 to 0.
  - Mirror fold: mod_q=0x0FF→idx 0xFF (addr 31, sub 7); mod_q=0x100→idx 0xFF (addr 31, sub 7); mod_q=0x1FF→idx 0x00 (addr 0, sub 0).

Test Plan:
- Reset/idle: assert rst mid-stream with nonzero phinc → all outputs 0 immediately. After release, slot counts 0..31 and wraps to 0.
- Accumulation:
  - Stimulus: phinc=0x00400 for slot 5 only, others 0, pm=0.
  - Required: on the k-th visit of slot 5, ph_o=k at E+3 and rom_addr=k[7:3] at E+2. Other slots stay ph_o=0.
- Key-on reset:
  - Stimulus: slot 5 accumulated to ph_o=0x2A3, then pg_rst_I=1 on one visit.
  - Required: that visit gives ph_o=0. The next visit (pg_rst=0) gives ph_o=1.
- Wrap/fold/sign:
  - Stimulus: phinc=0xFFC00 for slot 0.
  - Required: phase sequence 0x3FF, 0x3FE, ...; first visit has sign_o=1, mirror, idx=0x00, rom_addr=0, sub_o=0.
  - Check fold points 0x0FF/0x100/0x1FF per the Behaviour boundaries.
- Modulation: stored phase 0x3F0 with pm=0x020 → ph_o=0x010, sign_o=0. The next visit with pm=0 shows the unmodulated accumulator advanced by phinc only.
- cen gating: toggle cen 1-of-3 with fixed stimulus → identical output sequence to cen=1 when sampled on enabled edges. Outputs are stable while cen=0.
